// File: rtl/branch_target_table_if.sv
// Load/lookup bundle for the branch target table.
// master: loader + fetch side; slave: the table.
interface branch_target_table_if #(
  parameter int D = 12,
  parameter int A = 6
);
  logic         load_start;
  logic         load_valid;
  logic [D:0]   load_data;
  logic         load_last;
  logic         load_ready;
  logic         load_done;
  logic         lookup_valid;
  logic         lookup_ready;
  logic [A-1:0] lookup_addr;
  logic [D-1:0] pc_in;
  logic         target_valid;
  logic [D-1:0] target;
  logic         target_miss;

  modport master (
    output load_start, load_valid,
    output load_data, load_last,
    output lookup_valid, lookup_addr, pc_in,
    input  load_ready, load_done,
    input  lookup_ready,
    input  target_valid, target, target_miss
  );

  modport slave (
    input  load_start, load_valid,
    input  load_data, load_last,
    input  lookup_valid, lookup_addr, pc_in,
    output load_ready, load_done,
    output lookup_ready,
    output target_valid, target, target_miss
  );
endinterface

// File: rtl/branch_target_table.sv
// Run-time loadable branch target table; next-PC one cycle after lookup.
// Ports: Clk, Reset (sync, high), bus (slave: load stream + lookup).
module branch_target_table #(
  parameter int D     = 12,
  parameter int A     = 6,
  parameter int DEPTH = 64
) (
  input logic Clk,
  input logic Reset,
  branch_target_table_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [A:0] DEPTH_W = (A+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic          w_we;
  logic [D:0]    w_wdata;
  logic          w_done_nxt;
  logic          r_done;
  logic          r_tvalid;
  logic [D-1:0]  r_target;
  logic          r_miss;

  // Sized to a power of two so the slice of
  // lookup_addr indexes it directly; rows past
  // DEPTH are never written and never selected.
  logic [D:0] r_mem [2**IW];

  logic         w_acc;
  logic         w_miss;
  logic [D:0]   w_entry;
  logic [D-1:0] w_target;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_wdata     = '0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_we      = 1'b1;
        w_ptr_nxt = r_ptr + IW'(1);
        if (r_ptr == LAST) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (bus.load_start) begin
          w_state_nxt = S_LOAD;
          w_ptr_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (bus.load_valid) begin
          w_we      = 1'b1;
          w_wdata   = bus.load_data;
          w_ptr_nxt = r_ptr + IW'(1);
          // Table full ends the load even
          // without load_last.
          if (bus.load_last || r_ptr == LAST) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_we && !Reset)
      r_mem[r_ptr] <= w_wdata;
  end

  assign w_acc   = bus.lookup_valid
                 && (r_state == S_IDLE);
  assign w_miss  = {1'b0, bus.lookup_addr}
                 >= DEPTH_W;
  assign w_entry = r_mem[bus.lookup_addr[IW-1:0]];

  always_comb begin
    w_target = bus.pc_in;
    if (!w_miss) begin
      if (w_entry[D])
        w_target = w_entry[D-1:0];
      else
        w_target = bus.pc_in + w_entry[D-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tvalid <= 1'b0;
      r_target <= '0;
      r_miss   <= 1'b0;
    end else begin
      r_tvalid <= w_acc;
      if (w_acc) begin
        r_target <= w_target;
        r_miss   <= w_miss;
      end
    end
  end

  assign bus.load_ready   = (r_state == S_LOAD);
  assign bus.lookup_ready = (r_state == S_IDLE);
  assign bus.load_done    = r_done;
  assign bus.target_valid = r_tvalid;
  assign bus.target       = r_target;
  assign bus.target_miss  = r_miss;
endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: DEPTH=64 and DEPTH=20
// instances share stimulus; model checked every cycle.
module tb_branch_target_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [12:0] ld_data  = '0;
  logic        ld_last  = 1'b0;
  logic        lk_valid = 1'b0;
  logic [5:0]  lk_addr  = '0;
  logic [11:0] pc       = '0;

  branch_target_table_if #(.D(12), .A(6)) bus64 ();
  branch_target_table_if #(.D(12), .A(6)) bus20 ();

  assign bus64.load_start   = ld_start;
  assign bus64.load_valid   = ld_valid;
  assign bus64.load_data    = ld_data;
  assign bus64.load_last    = ld_last;
  assign bus64.lookup_valid = lk_valid;
  assign bus64.lookup_addr  = lk_addr;
  assign bus64.pc_in        = pc;
  assign bus20.load_start   = ld_start;
  assign bus20.load_valid   = ld_valid;
  assign bus20.load_data    = ld_data;
  assign bus20.load_last    = ld_last;
  assign bus20.lookup_valid = lk_valid;
  assign bus20.lookup_addr  = lk_addr;
  assign bus20.pc_in        = pc;

  branch_target_table #(
    .D(12), .A(6), .DEPTH(64)
  ) u64 (
    .Clk(clk), .Reset(rst), .bus(bus64)
  );

  branch_target_table #(
    .D(12), .A(6), .DEPTH(20)
  ) u20 (
    .Clk(clk), .Reset(rst), .bus(bus20)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: phase 0 clearing, 1 idle, 2 loading.
  int          dep [2] = '{64, 20};
  int          m_mode [2];
  int          m_cnt [2];
  logic [12:0] m_tab [2][64];
  logic        e_tv [2];
  logic [11:0] e_t [2];
  logic        e_miss [2];
  logic        e_done [2];
  logic        m_on = 1'b0;

  always @(posedge clk) begin
    logic acc;
    int   idx;
    for (int k = 0; k < 2; k++) begin
      acc = lk_valid && (m_mode[k] == 1);
      if (rst) begin
        m_mode[k] = 0;
        m_cnt[k]  = 0;
        e_tv[k]   = 1'b0;
        e_t[k]    = '0;
        e_miss[k] = 1'b0;
        e_done[k] = 1'b0;
      end else begin
        e_done[k] = 1'b0;
        e_tv[k]   = acc;
        if (acc) begin
          idx = int'(lk_addr);
          if (idx >= dep[k]) begin
            e_miss[k] = 1'b1;
            e_t[k]    = pc;
          end else begin
            e_miss[k] = 1'b0;
            if (m_tab[k][idx][12])
              e_t[k] = m_tab[k][idx][11:0];
            else
              e_t[k] = 12'(pc + m_tab[k][idx][11:0]);
          end
        end
        case (m_mode[k])
          0: begin
            m_cnt[k]++;
            if (m_cnt[k] == dep[k]) begin
              for (int i = 0; i < 64; i++)
                m_tab[k][i] = '0;
              m_mode[k] = 1;
            end
          end
          1: begin
            if (ld_start) begin
              m_mode[k] = 2;
              m_cnt[k]  = 0;
            end
          end
          default: begin
            if (ld_valid) begin
              m_tab[k][m_cnt[k]] = ld_data;
              m_cnt[k]++;
              if (ld_last || m_cnt[k] == dep[k]) begin
                m_mode[k] = 1;
                e_done[k] = 1'b1;
              end
            end
          end
        endcase
      end
    end
    if (rst) m_on = 1'b1;
  end

  always @(negedge clk) begin
    if (m_on) begin
      cmp("m64.tvalid", bus64.target_valid, e_tv[0]);
      cmp("m64.target", bus64.target, e_t[0]);
      cmp("m64.miss", bus64.target_miss, e_miss[0]);
      cmp("m64.done", bus64.load_done, e_done[0]);
      cmp("m64.lkrdy", bus64.lookup_ready,
          m_mode[0] == 1);
      cmp("m64.ldrdy", bus64.load_ready,
          m_mode[0] == 2);
      cmp("m20.tvalid", bus20.target_valid, e_tv[1]);
      cmp("m20.target", bus20.target, e_t[1]);
      cmp("m20.miss", bus20.target_miss, e_miss[1]);
      cmp("m20.done", bus20.load_done, e_done[1]);
      cmp("m20.lkrdy", bus20.lookup_ready,
          m_mode[1] == 1);
      cmp("m20.ldrdy", bus20.load_ready,
          m_mode[1] == 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [5:0] a,
                        input logic [11:0] p);
    lk_valid = 1'b1;
    lk_addr  = a;
    pc       = p;
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic word(input logic [12:0] d,
                      input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus64.lookup_ready && n < 200) begin
      tick();
      n++;
    end
    cmp(nm, n, 64);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp("rst.ldrdy", bus64.load_ready, 0);
    cmp("rst.tvalid", bus64.target_valid, 0);

    // 1: clear takes 64 cycles, zero entries hold PC
    wait_ready("clear_cycles");
    lookup(6'd5, 12'd100);
    cmp("t1.tvalid", bus64.target_valid, 1);
    cmp("t1.target", bus64.target, 100);
    cmp("t1.miss", bus64.target_miss, 0);
    tick();
    cmp("t1.tv_drop", bus64.target_valid, 0);
    cmp("t1.hold", bus64.target, 100);

    // 2: relative entries, negative offset
    start_load();
    word({1'b0, 12'd11}, 1'b0);
    word({1'b0, 12'd15}, 1'b0);
    word({1'b0, 12'hFEF}, 1'b1);
    cmp("t2.done", bus64.load_done, 1);
    tick();
    cmp("t2.done_pulse", bus64.load_done, 0);
    lookup(6'd2, 12'd40);
    cmp("t2.neg", bus64.target, 23);
    lookup(6'd1, 12'd40);
    cmp("t2.pos", bus64.target, 55);
    tick();

    // 3: absolute entry, then wrap-around
    start_load();
    word({1'b1, 12'h200}, 1'b1);
    tick();
    lookup(6'd0, 12'h7FF);
    cmp("t3.abs", bus64.target, 12'h200);
    start_load();
    word({1'b0, 12'd4}, 1'b1);
    tick();
    lookup(6'd0, 12'hFFE);
    cmp("t3.wrap", bus64.target, 12'h002);

    // 4: miss boundary on the 20-deep table
    lookup(6'd20, 12'd77);
    cmp("t4.miss20", bus20.target_miss, 1);
    cmp("t4.tgt20", bus20.target, 77);
    cmp("t4.nomiss64", bus64.target_miss, 0);
    lookup(6'd19, 12'd77);
    cmp("t4.last20", bus20.target_miss, 0);
    cmp("t4.lastt20", bus20.target, 77);
    tick();

    // 5: reset in the middle of a load
    start_load();
    word({1'b0, 12'd1}, 1'b0);
    word({1'b0, 12'd2}, 1'b0);
    word({1'b0, 12'd3}, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("t5.ldrdy", bus64.load_ready, 0);
    cmp("t5.lkrdy", bus64.lookup_ready, 0);
    cmp("t5.target", bus64.target, 0);
    wait_ready("reclear_cycles");
    lookup(6'd1, 12'd9);
    cmp("t5.cleared", bus64.target, 9);
    tick();

    // 6: lookup with load_start, then held lookup
    ld_start = 1'b1;
    lk_valid = 1'b1;
    lk_addr  = 6'd3;
    pc       = 12'd5;
    tick();
    ld_start = 1'b0;
    cmp("t6.tvalid", bus64.target_valid, 1);
    cmp("t6.target", bus64.target, 5);
    cmp("t6.ldrdy", bus64.load_ready, 1);
    lk_addr = 6'd4;
    pc      = 12'd6;
    cmp("t6.blocked", bus64.lookup_ready, 0);
    word({1'b1, 12'h123}, 1'b1);
    cmp("t6.done", bus64.load_done, 1);
    cmp("t6.no_tv", bus64.target_valid, 0);
    cmp("t6.lkrdy", bus64.lookup_ready, 1);
    tick();
    lk_valid = 1'b0;
    cmp("t6.held_tv", bus64.target_valid, 1);
    cmp("t6.held_t", bus64.target, 6);
    lookup(6'd0, 12'd1);
    cmp("t6.abs", bus64.target, 12'h123);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
- Programmable successor to the fixed branch-target lookup: a DEPTH-entry table of branch targets that is loaded at run time over a valid/ready stream.
- Each entry is tagged relative (offset added to the current PC) or absolute (jump address).
- Sits between the decoder's branch-index field and the PC register. It returns the resolved next-PC one cycle after a lookup.
- Entries are zero-cleared after reset, so unloaded entries hold the PC.

Parameters:
D, 12, PC / target width in bits
A, 6, lookup index width
DEPTH, 64, number of implemented entries (1 <= DEPTH <= 2**A)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
load_start  input  1  request table load (sampled only in IDLE)
load_valid  input  1  load_data is valid this cycle
load_data  input  D+1  bit D = mode (1 absolute, 0 relative); bits D-1:0 = target or two's-complement offset
load_last  input  1  marks final word of a load
load_ready  output  1  table accepts a load word this cycle
load_done  output  1  one-cycle pulse when a load completes
lookup_valid  input  1  lookup request
lookup_ready  output  1  lookup accepted this cycle
lookup_addr  input  A  entry index
pc_in  input  D  current PC, sampled with the lookup
target_valid  output  1  target/target_miss valid (registered)
target  output  D  resolved next-PC
target_miss  output  1  lookup_addr >= DEPTH

Behaviour:
- Reset (Clk edge with Reset=1) forces the following, regardless of the current state, including mid-LOAD:
  - state=CLEAR, ptr=0
  - load_ready=0, load_done=0, lookup_ready=0
  - target_valid=0, target=0, target_miss=0
- CLEAR:
  - Writes entry[ptr]={0,0} each cycle and increments ptr.
  - After writing entry DEPTH-1, goes to IDLE.
  - Takes exactly DEPTH cycles; lookup_ready=0 and load_ready=0 throughout.
- IDLE:
  - lookup_ready=1, load_ready=0.
  - load_start=1 -> LOAD with ptr=0 on the next cycle.
  - A lookup presented in the same cycle as load_start is still accepted.
- LOAD:
  - load_ready=1, lookup_ready=0.
  - On load_valid: write entry[ptr]=load_data, then ptr++.
  - Exit to IDLE on the accepted word with load_last=1, or on the write to entry DEPTH-1, whichever comes first.
  - load_done pulses high for the cycle after the exiting write.
  - Entries not written keep their previous contents.
  - load_valid=0 stalls the load indefinitely; no timeout.
- Lookup (accepted when lookup_valid && lookup_ready):
  - Next cycle: target_valid=1.
  - If lookup_addr >= DEPTH: target_miss=1, target=pc_in.
  - Else if entry mode=1: target=entry[D-1:0].
  - Else: target=(pc_in + entry[D-1:0]) mod 2**D. Wrap-around is silent; there is no overflow flag.
  - target_valid=0 in any cycle following no accepted lookup. target and target_miss then hold their last values.
  - Back-to-back lookups: one per cycle, fully pipelined, latency 1.
- Storage is written only in CLEAR/LOAD and read only in IDLE, so there is no read/write collision case.
- load_valid outside LOAD is ignored. lookup_valid outside IDLE is ignored; the requester must hold it until lookup_ready.

Test Plan:
1. Reset, then wait DEPTH=64 cycles -> lookup_ready rises on cycle 64. Lookup addr=5, pc_in=100 -> next cycle target_valid=1, target=100, miss=0.
2. Load entries 0..2 = {0,11},{0,15},{0,-17 (0xFEF)} with load_last on entry 2 -> load_done pulses once. Lookup addr=2, pc_in=40 -> target=23. Lookup addr=1, pc_in=40 -> target=55.
3. Load entry 0 = {1,0x200}, load_last -> lookup addr=0, pc_in=0x7FF -> target=0x200. Relative entry {0,4} with pc_in=0xFFE -> target=0x002 (wrap).
4. DEPTH=20: lookup addr=20, pc_in=77 -> target_miss=1, target=77. Lookup addr=19 -> miss=0.
5. Assert Reset after 3 load words -> load_ready=0 next cycle and state CLEAR. After DEPTH cycles, a lookup of the previously loaded entry 1 with pc_in=9 -> target=9.
6. In IDLE, drive load_start and lookup_valid together -> lookup accepted (target_valid next cycle). load_ready=1 on the following cycle. A lookup held during LOAD gets lookup_ready=0 until after load_done.
